vram_port_arbiter: RTL
======================

// Module: vram_port_arbiter
// PURPOSE
//  Shares the single vector-RAM BRAM port (CPU window 0x2000-0x3FFF) among three requesters:
//  - CPU direct reads.
//  - The CPU store-queue drain.
//  - Vector-generator (VG) display-list reads.
//  Sequences VG start: a VGGO is held off until all queued CPU writes have landed.
//  Sits between the address decoder/store queue and the BRAM_VECTOR bank.
// PARAMETERS
//  AW        13  BRAM word-address width (8 KiB window)
//  DW        8   data width
//  MAX_WAIT  4   cycles a waiting VG/queue request may be passed over before it is forced (>=1)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-low reset
//  cpu_rd_req   in   1   CPU read of vector RAM this cycle
//  cpu_addr     in   AW  CPU read address
//  cpu_rdata    out  DW  CPU read data, valid when cpu_rvalid
//  cpu_rvalid   out  1   one cycle after an accepted cpu_rd_req
//  q_valid      in   1   store queue non-empty (head entry valid)
//  q_full       in   1   store queue full
//  q_addr       in   AW  head write address
//  q_data       in   DW  head write data
//  q_ack        out  1   head written this cycle; drives the queue's canWrite/pop
//  vg_req       in   1   VG read request (held until vg_gnt)
//  vg_addr      in   AW  VG read address
//  vg_gnt       out  1   VG request accepted this cycle
//  vg_rdata     out  DW  VG read data, valid when vg_rvalid
//  vg_rvalid    out  1   one cycle after vg_gnt
//  vggo         in   1   CPU strobe to start the VG
//  vgrst        in   1   CPU strobe to reset the VG
//  vg_start     out  1   one-cycle start pulse to the VG after flush
//  vg_halted    out  1   VG idle/blocked (feeds HALT status bit)
//  bram_addr    out  AW  BRAM address
//  bram_wdata   out  DW  BRAM write data
//  bram_we      out  1   BRAM write enable
//  bram_rdata   in   DW  BRAM read data, 1-cycle latency
// BEHAVIOUR
//  Reset values (rst low, async):
//   - State = HALTED; vg_halted = 1.
//   - All strobes (q_ack, vg_gnt, vg_start, cpu_rvalid, vg_rvalid, bram_we) = 0.
//   - bram_addr = 0, bram_wdata = 0, rdata outputs = 0.
//   - Wait counters = 0; rr pointer = queue.
//  Grant (combinational, one grant per cycle):
//   - cpu_rd_req always wins (6502 cannot stall).
//   - Else in FLUSH the queue wins; vg_gnt is forced 0.
//   - Else if q_full, the queue wins.
//   - Else if either wait counter == MAX_WAIT, that requester wins (VG first if both).
//   - Else round-robin between queue and VG; pointer flips after each queue/VG grant.
//  Waiting: a requester's wait counter increments while it requests and loses; clears on grant; saturates at MAX_WAIT.
//  Port drive: bram_addr/wdata/we are driven combinationally from the winner. Idle: bram_we = 0, addr holds last value.
//  Read return: the granted read owner is registered; rdata/rvalid go to that owner one cycle later.
//   - Back-to-back reads by different owners are legal.
//  State machine:
//   - HALTED: vg_halted = 1.
//     * On vggo: to FLUSH if q_valid, else to RUN with vg_start = 1 next cycle.
//   - FLUSH: queue-only drain.
//     * When q_valid = 0 and no q_ack this cycle: to RUN, emit vg_start.
//   - RUN: vg_halted = 0.
//     * On vgrst: to HALTED.
//     * VG completion is signalled by vg_req low plus vgrst, or by a new vggo, which re-enters FLUSH.
//  Simultaneous events:
//   - vgrst wins over vggo in the same cycle (go to HALTED).
//   - A vggo during FLUSH is ignored.
//   - A reset during FLUSH abandons the flush; queue contents are untouched.
//   - A VG request arriving while HALTED is not granted.
// CONFIGURATION
//  VRAM_ARB_STATS_EN defined:
//   - Adds output conflict_cnt[15:0]: counts cycles with >=2 simultaneous requesters.
//   - Saturates at 16'hFFFF; clears on reset and on vgrst.
//  Undefined: port absent; no counter logic.
// STRUCTURE
//  Package vram_arb_pkg holds:
//   - typedef enum {ARB_HALTED, ARB_FLUSH, ARB_RUN} arb_state_t.
//   - typedef enum {OWN_NONE, OWN_CPU, OWN_Q, OWN_VG} owner_t.
//   - VRAM_BASE = 16'h2000.
//  One sub-module, vram_wait_ctr: saturating per-requester wait counter, instantiated twice.
// TESTING
//  1 Reset: rst low mid-RUN -> all strobes 0 and vg_halted = 1 immediately; outputs hold while low.
//  2 CPU + VG + queue requesting together:
//    - Expect CPU granted; cpu_rvalid next cycle with cpu_rdata = BRAM[cpu_addr].
//    - VG and queue then alternate.
//  3 VG request held, queue alternating, MAX_WAIT = 4 -> vg_gnt within 5 cycles of request.
//  4 Queue holds 3 writes (0x010=AA, 0x011=BB, 0x012=CC), vggo pulsed:
//    - Expect 3 q_ack and no vg_gnt, then vg_start one cycle after the last write.
//    - A VG read of 0x012 then returns CC.
//  5 vggo and vgrst in the same cycle -> state HALTED; no vg_start.
//  6 q_full = 1 with VG wait at 2 -> queue granted ahead of VG.
//    With VRAM_ARB_STATS_EN: conflict_cnt increments by 1 per contended cycle.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the vector-RAM port arbiter.
package vram_arb_pkg;

  localparam logic [15:0] VRAM_BASE = 16'h2000;
  localparam int unsigned CONFLICT_W = 16;

  typedef enum logic [1:0] {
    ARB_HALTED = 2'd0,
    ARB_FLUSH  = 2'd1,
    ARB_RUN    = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_Q    = 2'd2,
    OWN_VG   = 2'd3
  } owner_t;

  // Number of requesters active in one cycle.
  function automatic logic [1:0] req_count(input logic a, input logic b, input logic c);
    return 2'(a) + 2'(b) + 2'(c);
  endfunction

endpackage

// File: rtl/vram_wait_ctr.sv
// Saturating wait counter: counts cycles a requester asks and loses, clears on grant.
module vram_wait_ctr #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_at_max
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_gnt) begin
      r_cnt <= '0;
    end else if (i_req && (r_cnt != MAX_C)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_at_max = (r_cnt == MAX_C);

endmodule

// File: rtl/vram_port_arbiter.sv
// Arbitrates the vector-RAM BRAM port between CPU reads, store-queue drain and VG reads,
// and sequences VG start behind a queue flush. Define VRAM_ARB_STATS_EN for conflict_cnt.
module vram_port_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned AW       = 13,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rd_req,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          q_valid,
  input  logic          q_full,
  input  logic [AW-1:0] q_addr,
  input  logic [DW-1:0] q_data,
  output logic          q_ack,
  input  logic          vg_req,
  input  logic [AW-1:0] vg_addr,
  output logic          vg_gnt,
  output logic [DW-1:0] vg_rdata,
  output logic          vg_rvalid,
  input  logic          vggo,
  input  logic          vgrst,
  output logic          vg_start,
  output logic          vg_halted,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_wdata,
  output logic          bram_we,
  input  logic [DW-1:0] bram_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [CONFLICT_W-1:0] conflict_cnt
`endif
);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  owner_t        w_owner;
  owner_t        r_rd_owner;
  logic          r_rr_q;
  logic          r_vg_start;
  logic          w_vg_start_nxt;
  logic          w_flush_done;
  logic          w_vg_req;
  logic          w_q_at_max;
  logic          w_vg_at_max;
  logic [AW-1:0] r_last_addr;
  logic [DW-1:0] r_last_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_vg_rdata;

  // The VG only competes for the port while running.
  assign w_vg_req = vg_req && (r_state == ARB_RUN);

  vram_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_q_wait (
    .clk      (clk),
    .rst_n    (rst),
    .i_req    (q_valid),
    .i_gnt    (q_ack),
    .o_at_max (w_q_at_max)
  );

  vram_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_vg_wait (
    .clk      (clk),
    .rst_n    (rst),
    .i_req    (w_vg_req),
    .i_gnt    (vg_gnt),
    .o_at_max (w_vg_at_max)
  );

  // Grant priority: CPU, flush drain, full queue, starved requester, round-robin.
  always_comb begin
    w_owner = OWN_NONE;
    if (!rst) begin
      w_owner = OWN_NONE;
    end else if (cpu_rd_req) begin
      w_owner = OWN_CPU;
    end else if (r_state == ARB_FLUSH) begin
      if (q_valid) w_owner = OWN_Q;
    end else if (q_full && q_valid) begin
      w_owner = OWN_Q;
    end else if (w_vg_at_max && w_vg_req) begin
      w_owner = OWN_VG;
    end else if (w_q_at_max && q_valid) begin
      w_owner = OWN_Q;
    end else if (q_valid && w_vg_req) begin
      w_owner = r_rr_q ? OWN_Q : OWN_VG;
    end else if (q_valid) begin
      w_owner = OWN_Q;
    end else if (w_vg_req) begin
      w_owner = OWN_VG;
    end
  end

  assign q_ack   = (w_owner == OWN_Q);
  assign vg_gnt  = (w_owner == OWN_VG);
  assign bram_we = q_ack;

  // Port mux; address and write data hold their last values when idle.
  always_comb begin
    bram_addr  = r_last_addr;
    bram_wdata = r_last_wdata;
    case (w_owner)
      OWN_CPU: bram_addr = cpu_addr;
      OWN_Q: begin
        bram_addr  = q_addr;
        bram_wdata = q_data;
      end
      OWN_VG:  bram_addr = vg_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_addr  <= '0;
      r_last_wdata <= '0;
      r_rd_owner   <= OWN_NONE;
      r_rr_q       <= 1'b1;
    end else begin
      r_last_addr  <= bram_addr;
      r_last_wdata <= bram_wdata;
      if ((w_owner == OWN_CPU) || (w_owner == OWN_VG)) r_rd_owner <= w_owner;
      else                                             r_rd_owner <= OWN_NONE;
      if (q_ack)       r_rr_q <= 1'b0;
      else if (vg_gnt) r_rr_q <= 1'b1;
    end
  end

  // Read return: BRAM data is steered to the owner registered last cycle.
  assign cpu_rvalid = (r_rd_owner == OWN_CPU);
  assign vg_rvalid  = (r_rd_owner == OWN_VG);
  assign cpu_rdata  = cpu_rvalid ? bram_rdata : r_cpu_rdata;
  assign vg_rdata   = vg_rvalid  ? bram_rdata : r_vg_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpu_rdata <= '0;
      r_vg_rdata  <= '0;
    end else begin
      r_cpu_rdata <= cpu_rdata;
      r_vg_rdata  <= vg_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ARB_HALTED;
      r_vg_start <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_vg_start <= w_vg_start_nxt;
    end
  end

  // VG sequencing; vgrst always dominates vggo.
  always_comb begin
    w_state_nxt    = r_state;
    w_vg_start_nxt = 1'b0;
    w_flush_done   = 1'b0;
    case (r_state)
      ARB_HALTED, ARB_RUN: begin
        if (vgrst) begin
          w_state_nxt = ARB_HALTED;
        end else if (vggo) begin
          if (q_valid) begin
            w_state_nxt = ARB_FLUSH;
          end else begin
            w_state_nxt    = ARB_RUN;
            w_vg_start_nxt = 1'b1;
          end
        end
      end
      ARB_FLUSH: begin
        if (vgrst) begin
          w_state_nxt = ARB_HALTED;
        end else if (!q_valid && !q_ack) begin
          w_state_nxt  = ARB_RUN;
          w_flush_done = 1'b1;
        end
      end
      default: w_state_nxt = ARB_HALTED;
    endcase
  end

  assign vg_start  = r_vg_start | w_flush_done;
  assign vg_halted = (r_state != ARB_RUN);

`ifdef VRAM_ARB_STATS_EN
  logic [CONFLICT_W-1:0] r_conflict_cnt;
  logic                  w_conflict;

  assign w_conflict = (req_count(cpu_rd_req, q_valid, w_vg_req) >= 2'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conflict_cnt <= '0;
    end else if (vgrst) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != {CONFLICT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + CONFLICT_W'(1);
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
